uart_ctrl_fifo_ptr_tracker: RTL and testbench
=============================================

# uart_ctrl_fifo_ptr_tracker

Synthesizable occupancy tracker for the UART controller's TX and RX FIFOs. Counts push/pop strobes from the FIFO datapaths and drives the `tx_fifo_ptr` and `rx_fifo_ptr` levels that the white-box coverage interface samples. It also generates the RX trigger-level indication, the TX-empty indication, and sticky overflow/underflow error flags for the interrupt logic.

## Interface
- `DEPTH`, 16, FIFO depth in entries; must be at least 16.
- `PTR_W`, `$clog2(DEPTH)+1`, pointer/count width; holds 0..DEPTH.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `tx_push`, `tx_pop` in 1: TX FIFO write and read strobes, one entry each.
- `rx_push`, `rx_pop` in 1: RX FIFO write and read strobes.
- `tx_fifo_rst`, `rx_fifo_rst` in 1: FCR-style FIFO clears.
- `rx_trig_sel` in 2: RX trigger select (0→1, 1→4, 2→8, 3→DEPTH-2 entries).
- `clr_flags` in 1: clears the sticky flags (and high-water marks).
- `tx_fifo_ptr` out PTR_W: TX occupancy.
- `rx_fifo_ptr` out PTR_W: RX occupancy.
- `tx_empty` out 1: high when `tx_fifo_ptr` is 0.
- `rx_trig` out 1: high when `rx_fifo_ptr` is at or above the selected level.
- `tx_ovf`, `rx_ovf`, `tx_udf`, `rx_udf` out 1: sticky overflow/underflow flags.
- `tx_hwm`, `rx_hwm` out PTR_W: occupancy high-water marks (see Configuration).

## Operation
- Each direction has its own independent counter. Per cycle, priority is: `reset` > `*_fifo_rst` > push/pop.
- `*_fifo_rst` forces the count to 0. It does not clear flags.
- Push only, count < DEPTH: +1. Push only at DEPTH: count unchanged and `*_ovf` set.
- Pop only, count > 0: −1. Pop only at 0: count unchanged and `*_udf` set.
- Push and pop together, count in 1..DEPTH: count unchanged, no flag.
- Push and pop together at count 0: push accepted, pop rejected. Count becomes 1 and `*_udf` is set.
- Flags are sticky until `clr_flags` or `reset`. If `clr_flags` and a new error occur in the same cycle, the flag ends set.
- Count arithmetic is unsigned PTR_W and must never wrap. Saturation at 0 and DEPTH is guaranteed by the rules above.
- `rx_trig_sel` may change at any time. `rx_trig` follows it on the next registered compare.

## Timing
- Counts, flags and HWMs are registered. A strobe in cycle N is visible on outputs in cycle N+1.
- `tx_empty` and `rx_trig` are registered, computed from the next-state count, so they are aligned with the pointer outputs (also N+1).
- Reset values: all pointers 0, all flags 0, HWMs 0, `tx_empty` = 1, `rx_trig` = 0.
- A `reset` asserted mid-stream discards any strobes in that cycle. Outputs hold their reset values on the following cycle.

## Configuration
- The macro is `UART_CTRL_FIFO_HWM_EN`.
- Defined:
  - `tx_hwm`/`rx_hwm` each register the maximum count reached since the last `reset`/`clr_flags`.
  - If `clr_flags` and an update occur in the same cycle, the HWM loads the current next-state count.
- Undefined: the HWM ports remain but are tied to 0, and no HWM registers are built.

## Structure
- Package `uart_ctrl_ptr_pkg` contains:
  - `rx_trig_sel_e` enum (TRIG_1, TRIG_4, TRIG_8, TRIG_HI);
  - function `trig_level(sel, depth)`;
  - default DEPTH constant.
- Sub-module `uart_ctrl_fifo_cnt` holds one direction's counter, flags and HWM. It is instantiated twice; the top level adds the trigger compare and the empty decode.

## Test plan
- Reset, then idle: pointers 0, `tx_empty` = 1, `rx_trig` = 0, all flags 0 held for 10 cycles.
- 17 consecutive `rx_push` (DEPTH=16): `rx_fifo_ptr` reaches 16 at cycle 16. On the 17th push, `rx_ovf` = 1 one cycle later and the pointer stays 16.
- `rx_trig_sel`=2 with pushes: `rx_trig` rises the cycle `rx_fifo_ptr` becomes 8. Switching to sel=3 at count 8 drops `rx_trig` next cycle; it reasserts at 14.
- `tx_pop` at empty, then push+pop together at 0: `tx_udf` = 1 and the pointer becomes 1. `clr_flags` then returns `tx_udf` to 0.
- Fill TX to 5, assert `tx_fifo_rst` together with `tx_push`: pointer 0 next cycle, `tx_empty` = 1, no flag change.
- With `UART_CTRL_FIFO_HWM_EN`: push 9 then pop 4 → `rx_hwm` = 9. After `clr_flags` → `rx_hwm` = 5. Without the macro, `rx_hwm` stays 0 throughout.

Source files
------------

// File: rtl/uart_ctrl_ptr_pkg.sv
// Shared types, defaults and helpers for the UART FIFO occupancy tracker.
package uart_ctrl_ptr_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        TRIG_1  = 2'd0,
        TRIG_4  = 2'd1,
        TRIG_8  = 2'd2,
        TRIG_HI = 2'd3
    } rx_trig_sel_e;

    // RX trigger threshold in entries; TRIG_HI sits two entries below full.
    function automatic int unsigned trig_level(rx_trig_sel_e sel, int unsigned depth);
        int unsigned lvl;
        case (sel)
            TRIG_1:  lvl = 1;
            TRIG_4:  lvl = 4;
            TRIG_8:  lvl = 8;
            default: lvl = depth - 2;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_ctrl_fifo_cnt.sv
// One FIFO direction: saturating occupancy counter, sticky ovf/udf flags and
// optional high-water mark (built only when UART_CTRL_FIFO_HWM_EN is defined).
module uart_ctrl_fifo_cnt
    import uart_ctrl_ptr_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             fifo_rst,
    input  logic             clr_flags,
    output logic [PTR_W-1:0] cnt,
    output logic [PTR_W-1:0] cnt_d_c,
    output logic             ovf,
    output logic             udf,
    output logic [PTR_W-1:0] hwm
);

    localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);

    logic [PTR_W-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;
    logic             udf_d, udf_q;
    logic             ovf_set, udf_set;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (fifo_rst) begin
            cnt_d = '0;
        end else if (push && !pop) begin
            if (cnt_q == FULL) ovf_set = 1'b1;
            else               cnt_d   = cnt_q + PTR_W'(1);
        end else if (pop && !push) begin
            if (cnt_q == '0) udf_set = 1'b1;
            else             cnt_d   = cnt_q - PTR_W'(1);
        end else if (push && pop && (cnt_q == '0)) begin
            // Empty FIFO: the write lands, the read has nothing to take.
            cnt_d   = PTR_W'(1);
            udf_set = 1'b1;
        end
        ovf_d = (ovf_q && !clr_flags) || ovf_set;
        udf_d = (udf_q && !clr_flags) || udf_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_d_c = cnt_d;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

`ifdef UART_CTRL_FIFO_HWM_EN
    logic [PTR_W-1:0] hwm_d, hwm_q;

    // A clear restarts tracking from the count being written this cycle.
    always_comb begin
        hwm_d = hwm_q;
        if (clr_flags || (cnt_d > hwm_q)) hwm_d = cnt_d;
    end

    always_ff @(posedge clock) begin
        if (reset) hwm_q <= '0;
        else       hwm_q <= hwm_d;
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule

// File: rtl/uart_ctrl_fifo_ptr_tracker.sv
// TX/RX FIFO occupancy tracker with registered empty/trigger decode.
// Optional HWM registers: define UART_CTRL_FIFO_HWM_EN.
module uart_ctrl_fifo_ptr_tracker
    import uart_ctrl_ptr_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tx_push,
    input  logic             tx_pop,
    input  logic             rx_push,
    input  logic             rx_pop,
    input  logic             tx_fifo_rst,
    input  logic             rx_fifo_rst,
    input  logic [1:0]       rx_trig_sel,
    input  logic             clr_flags,
    output logic [PTR_W-1:0] tx_fifo_ptr,
    output logic [PTR_W-1:0] rx_fifo_ptr,
    output logic             tx_empty,
    output logic             rx_trig,
    output logic             tx_ovf,
    output logic             rx_ovf,
    output logic             tx_udf,
    output logic             rx_udf,
    output logic [PTR_W-1:0] tx_hwm,
    output logic [PTR_W-1:0] rx_hwm
);

    logic [PTR_W-1:0] tx_cnt_d, rx_cnt_d;
    logic [PTR_W-1:0] trig_lvl;
    logic             tx_empty_d, tx_empty_q;
    logic             rx_trig_d, rx_trig_q;

    uart_ctrl_fifo_cnt #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tx_cnt (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .pop       (tx_pop),
        .fifo_rst  (tx_fifo_rst),
        .clr_flags (clr_flags),
        .cnt       (tx_fifo_ptr),
        .cnt_d_c   (tx_cnt_d),
        .ovf       (tx_ovf),
        .udf       (tx_udf),
        .hwm       (tx_hwm)
    );

    uart_ctrl_fifo_cnt #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rx_cnt (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .pop       (rx_pop),
        .fifo_rst  (rx_fifo_rst),
        .clr_flags (clr_flags),
        .cnt       (rx_fifo_ptr),
        .cnt_d_c   (rx_cnt_d),
        .ovf       (rx_ovf),
        .udf       (rx_udf),
        .hwm       (rx_hwm)
    );

    // Decode from next-state counts so these line up with the pointer outputs.
    always_comb begin
        trig_lvl   = PTR_W'(trig_level(rx_trig_sel_e'(rx_trig_sel), DEPTH));
        tx_empty_d = (tx_cnt_d == '0);
        rx_trig_d  = (rx_cnt_d >= trig_lvl);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_empty_q <= 1'b1;
            rx_trig_q  <= 1'b0;
        end else begin
            tx_empty_q <= tx_empty_d;
            rx_trig_q  <= rx_trig_d;
        end
    end

    assign tx_empty = tx_empty_q;
    assign rx_trig  = rx_trig_q;

endmodule

// File: tb/tb_uart_ctrl_fifo_ptr_tracker.sv
// Bench for uart_ctrl_fifo_ptr_tracker: directed plan steps plus random strobes
// against an occupancy model; HWM expectations follow UART_CTRL_FIFO_HWM_EN.
module tb_uart_ctrl_fifo_ptr_tracker;

    localparam int DEPTH = 16;
    localparam int PTR_W = 5;

    logic             clock = 1'b0;
    logic             reset, tx_push, tx_pop, rx_push, rx_pop;
    logic             tx_fifo_rst, rx_fifo_rst, clr_flags;
    logic [1:0]       rx_trig_sel;
    logic [PTR_W-1:0] tx_fifo_ptr, rx_fifo_ptr, tx_hwm, rx_hwm;
    logic             tx_empty, rx_trig, tx_ovf, rx_ovf, tx_udf, rx_udf;

    uart_ctrl_fifo_ptr_tracker #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .tx_push(tx_push), .tx_pop(tx_pop), .rx_push(rx_push), .rx_pop(rx_pop),
        .tx_fifo_rst(tx_fifo_rst), .rx_fifo_rst(rx_fifo_rst),
        .rx_trig_sel(rx_trig_sel), .clr_flags(clr_flags),
        .tx_fifo_ptr(tx_fifo_ptr), .rx_fifo_ptr(rx_fifo_ptr),
        .tx_empty(tx_empty), .rx_trig(rx_trig),
        .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .tx_udf(tx_udf), .rx_udf(rx_udf),
        .tx_hwm(tx_hwm), .rx_hwm(rx_hwm)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Model state, index 0 = TX, 1 = RX.
    int m_cnt [2];
    bit m_ovf [2];
    bit m_udf [2];
    int m_hwm [2];
    int m_lvl;
    bit model_ok = 1'b0;

`ifdef UART_CTRL_FIFO_HWM_EN
    localparam bit HWM_ON = 1'b1;
`else
    localparam bit HWM_ON = 1'b0;
`endif

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int lvl_of(int sel);
        int t [4];
        t = '{1, 4, 8, DEPTH - 2};
        return t[sel];
    endfunction

    function automatic void upd(int d, bit push, bit pop, bit frst, bit clr);
        bit eo, eu;
        eo = 1'b0;
        eu = 1'b0;
        if (frst) m_cnt[d] = 0;
        else if (push && !pop) begin
            if (m_cnt[d] < DEPTH) m_cnt[d]++; else eo = 1'b1;
        end else if (pop && !push) begin
            if (m_cnt[d] > 0) m_cnt[d]--; else eu = 1'b1;
        end else if (push && pop && m_cnt[d] == 0) begin
            m_cnt[d] = 1;
            eu = 1'b1;
        end
        m_ovf[d] = (clr ? 1'b0 : m_ovf[d]) | eo;
        m_udf[d] = (clr ? 1'b0 : m_udf[d]) | eu;
        if (clr || m_cnt[d] > m_hwm[d]) m_hwm[d] = m_cnt[d];
    endfunction

    task automatic step(input bit tp, input bit tpo, input bit rp, input bit rpo,
                        input bit trst, input bit rrst, input int sel,
                        input bit clr, input bit rst);
        tx_push = tp; tx_pop = tpo; rx_push = rp; rx_pop = rpo;
        tx_fifo_rst = trst; rx_fifo_rst = rrst;
        rx_trig_sel = 2'(sel); clr_flags = clr; reset = rst;
        @(posedge clock);
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_cnt[d] = 0; m_ovf[d] = 0; m_udf[d] = 0; m_hwm[d] = 0;
            end
            model_ok = 1'b1;
        end else begin
            upd(0, tp, tpo, trst, clr);
            upd(1, rp, rpo, rrst, clr);
        end
        m_lvl = lvl_of(sel);
        #1;
    endtask

    // Cycle-by-cycle compare of every output against the model.
    always @(negedge clock) begin
        if (model_ok) begin
            check("tx_ptr", int'(tx_fifo_ptr), m_cnt[0]);
            check("rx_ptr", int'(rx_fifo_ptr), m_cnt[1]);
            check("tx_empty", int'(tx_empty), int'(m_cnt[0] == 0));
            check("rx_trig", int'(rx_trig), int'(m_cnt[1] >= m_lvl));
            check("tx_ovf", int'(tx_ovf), int'(m_ovf[0]));
            check("rx_ovf", int'(rx_ovf), int'(m_ovf[1]));
            check("tx_udf", int'(tx_udf), int'(m_udf[0]));
            check("rx_udf", int'(rx_udf), int'(m_udf[1]));
            check("tx_hwm", int'(tx_hwm), HWM_ON ? m_hwm[0] : 0);
            check("rx_hwm", int'(rx_hwm), HWM_ON ? m_hwm[1] : 0);
        end
    end

    initial begin
        step(0,0,0,0,0,0,0,0,1);
        step(0,0,0,0,0,0,0,0,1);
        // Idle after reset: literal reset values for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            step(0,0,0,0,0,0,0,0,0);
            check("idle_ptrs", int'({tx_fifo_ptr, rx_fifo_ptr}), 0);
            check("idle_empty", int'(tx_empty), 1);
            check("idle_flags", int'({rx_trig, tx_ovf, rx_ovf, tx_udf, rx_udf}), 0);
        end

        // 17 RX pushes: saturate at 16, overflow on the 17th.
        for (int i = 1; i <= 17; i++) begin
            step(0,0,1,0,0,0,0,0,0);
            check("rx_fill_ptr", int'(rx_fifo_ptr), (i > 16) ? 16 : i);
        end
        check("rx_ovf_17th", int'(rx_ovf), 1);

        // Trigger select 2 then 3.
        step(0,0,0,0,0,1,2,1,0);
        check("rx_clr_ovf", int'(rx_ovf), 0);
        for (int i = 1; i <= 8; i++) begin
            step(0,0,1,0,0,0,2,0,0);
            if (i == 7) check("trig8_below", int'(rx_trig), 0);
            if (i == 8) check("trig8_hit", int'(rx_trig), 1);
        end
        step(0,0,0,0,0,0,3,0,0);
        check("trig_sel3_drop", int'(rx_trig), 0);
        for (int i = 9; i <= 14; i++) begin
            step(0,0,1,0,0,0,3,0,0);
            if (i == 13) check("trig14_below", int'(rx_trig), 0);
            if (i == 14) check("trig14_hit", int'(rx_trig), 1);
        end

        // TX underflow, push+pop at empty, then clear.
        step(0,1,0,0,0,0,3,0,0);
        check("tx_udf_pop0", int'(tx_udf), 1);
        check("tx_ptr_pop0", int'(tx_fifo_ptr), 0);
        step(1,1,0,0,0,0,3,0,0);
        check("tx_ptr_pp0", int'(tx_fifo_ptr), 1);
        step(0,0,0,0,0,0,3,1,0);
        check("tx_udf_clr", int'(tx_udf), 0);

        // Fill TX to 5, then FIFO reset with a concurrent push.
        for (int i = 0; i < 4; i++) step(1,0,0,0,0,0,3,0,0);
        check("tx_ptr_5", int'(tx_fifo_ptr), 5);
        step(1,0,0,0,1,0,3,0,0);
        check("tx_rst_ptr", int'(tx_fifo_ptr), 0);
        check("tx_rst_empty", int'(tx_empty), 1);
        check("tx_rst_flags", int'({tx_ovf, tx_udf}), 0);

        // High-water mark: push 9, pop 4, clear.
        step(0,0,0,0,0,1,0,1,0);
        for (int i = 0; i < 9; i++) step(0,0,1,0,0,0,0,0,0);
        for (int i = 0; i < 4; i++) step(0,0,0,1,0,0,0,0,0);
        check("rx_hwm_9", int'(rx_hwm), HWM_ON ? 9 : 0);
        step(0,0,0,0,0,0,0,1,0);
        check("rx_hwm_clr5", int'(rx_hwm), HWM_ON ? 5 : 0);

        // Random strobes with rare clears and resets.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0,
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
        end
        // Push-biased and pop-biased bursts to reach both limits.
        for (int i = 0; i < 400; i++) begin
            bit bias;
            bias = (i < 200);
            step(bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 0, 0, int'($urandom_range(0, 3)), $urandom_range(0, 49) == 0, 0);
        end

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
